// File: rtl/servant_spi_arbiter.sv
// servant_spi_arbiter: two-master (instruction / data) to one-slave Wishbone arbiter in front of
// the SPI RAM port. After reset it runs a status read and a write-enable cycle on the RAM, then
// alternates the port between the CPU buses with one cyc-low cycle between slave transactions.
// Optional macro SPI_ARB_TIMEOUT_EN adds a slave-ack timeout with a sticky timeout_err flag.
`timescale 1ns / 1ps

module servant_spi_arbiter #(
  parameter int unsigned ADDRESS_WIDTH  = 24,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [ADDRESS_WIDTH-1:2] i_wb_adr,
  input  logic                     i_wb_cyc,
  output logic [31:0]              i_wb_rdt,
  output logic                     i_wb_ack,
  input  logic [ADDRESS_WIDTH-1:2] d_wb_adr,
  input  logic [31:0]              d_wb_dat,
  input  logic [3:0]               d_wb_sel,
  input  logic                     d_wb_we,
  input  logic                     d_wb_cyc,
  output logic [31:0]              d_wb_rdt,
  output logic                     d_wb_ack,
  output logic [ADDRESS_WIDTH-1:2] s_wb_adr,
  output logic [31:0]              s_wb_dat,
  output logic [3:0]               s_wb_sel,
  output logic                     s_wb_we,
  output logic                     s_wb_cyc,
  input  logic [31:0]              s_wb_rdt,
  input  logic                     s_wb_ack,
  output logic                     init_done,
  output logic                     timeout_err
);

  typedef enum logic [2:0] {
    StInitStatus,
    StInitWen,
    StIdle,
    StGrantI,
    StGrantD,
    StRelease
  } state_e;

  state_e state_q, state_d;
  state_e ret_q, ret_d;
  state_e arb_state;
  logic   last_d_q, last_d_d;  // 1 when the data master was served last
  logic   init_done_q, init_done_d;
  logic   pick_i;
  logic   slave_done;
  logic   tmo;

  logic [ADDRESS_WIDTH-1:2] adr_q, adr_d;
  logic [31:0]              dat_q, dat_d;
  logic [3:0]               sel_q, sel_d;
  logic                     we_q, we_d;
  logic                     cyc_q, cyc_d;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        tmo_err_q;

  assign tmo = cyc_q && !s_wb_ack && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Ack-wait counter: held at zero while cyc is low, so it starts fresh in every cyc state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (!cyc_q) begin
        tmo_cnt_q <= '0;
      end else if (!s_wb_ack) begin
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
      end
      if (tmo) begin
        tmo_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Acks are only meaningful while we actually drive cyc; stray acks elsewhere are ignored.
  assign slave_done = cyc_q && (s_wb_ack || tmo);

  // Round-robin pick: on contention serve the master opposite the one served last.
  assign pick_i    = i_wb_cyc && (!d_wb_cyc || last_d_q);
  assign arb_state = pick_i ? StGrantI : (d_wb_cyc ? StGrantD : StIdle);

  // State and slave-side registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StInitStatus;
      ret_q       <= StInitWen;
      last_d_q    <= 1'b1;
      init_done_q <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      last_d_q    <= last_d_d;
      init_done_q <= init_done_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
    end
  end

  // Next-state: init sequence, arbitration, and the single release cycle.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    last_d_d    = last_d_q;
    init_done_d = init_done_q;
    case (state_q)
      StInitStatus: begin
        if (slave_done) begin
          state_d = StRelease;
          ret_d   = StInitWen;
        end
      end
      StInitWen: begin
        if (slave_done) begin
          state_d     = StRelease;
          ret_d       = StIdle;
          init_done_d = 1'b1;
        end
      end
      StIdle: state_d = arb_state;
      StGrantI: begin
        if (slave_done) begin
          state_d  = StRelease;
          last_d_d = 1'b0;
        end
      end
      StGrantD: begin
        if (slave_done) begin
          state_d  = StRelease;
          last_d_d = 1'b1;
        end
      end
      // The release cycle doubles as the arbitration cycle, keeping the cyc-low gap to one.
      StRelease: state_d = (ret_q == StIdle) ? arb_state : ret_q;
      default:   state_d = StInitStatus;
    endcase
  end

  // Slave fields: loaded when a state is entered, held for the whole transaction.
  always_comb begin
    cyc_d = 1'b0;
    adr_d = adr_q;
    dat_d = dat_q;
    sel_d = sel_q;
    we_d  = we_q;
    case (state_d)
      StInitStatus: begin
        cyc_d = 1'b1;
        adr_d = '0;
        dat_d = '0;
        sel_d = 4'h0;
        we_d  = 1'b0;
      end
      StInitWen: begin
        cyc_d = 1'b1;
        adr_d = '0;
        dat_d = '0;
        sel_d = 4'h0;
        we_d  = 1'b1;
      end
      StGrantI: begin
        cyc_d = 1'b1;
        if (state_q != StGrantI) begin
          adr_d = i_wb_adr;
          dat_d = '0;
          sel_d = 4'hF;
          we_d  = 1'b0;
        end
      end
      StGrantD: begin
        cyc_d = 1'b1;
        if (state_q != StGrantD) begin
          adr_d = d_wb_adr;
          dat_d = d_wb_dat;
          sel_d = d_wb_sel;
          we_d  = d_wb_we;
        end
      end
      default: ;
    endcase
  end

  assign i_wb_ack  = (state_q == StGrantI) && slave_done;
  assign d_wb_ack  = (state_q == StGrantD) && slave_done;
  // A timed-out transaction returns all ones instead of whatever is on the slave bus.
  assign i_wb_rdt  = tmo ? 32'hFFFF_FFFF : s_wb_rdt;
  assign d_wb_rdt  = tmo ? 32'hFFFF_FFFF : s_wb_rdt;
  assign s_wb_adr  = adr_q;
  assign s_wb_dat  = dat_q;
  assign s_wb_sel  = sel_q;
  assign s_wb_we   = we_q;
  assign s_wb_cyc  = cyc_q;
  assign init_done = init_done_q;

endmodule
